// File: rtl/opendap_ap_pkg.sv
// Shared widths, limits and FSM encoding for the OpenDAP AP multiplexer.
package opendap_ap_pkg;

    localparam int AP_SEL_W  = 8;
    localparam int AP_ADDR_W = 6;
    localparam int AP_DATA_W = 32;
    localparam int N_AP_MAX  = 8;
    localparam int CNT_W     = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } ap_state_e;

endpackage

// File: rtl/opendap_ap_timeout.sv
// BUSY-cycle counter; flags the terminal count that triggers a forced abort.
module opendap_ap_timeout
    import opendap_ap_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic swclk,
    input  logic rst_por,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge swclk) begin
        if (rst_por) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A zero limit disables the timeout entirely.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign tc = 1'b0;
        end else begin : g_timeout
            assign tc = enable & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/opendap_ap_mux.sv
// Routes one upstream AP access to one of N_AP downstream APs, tracks its
// completion, and forces an abort if the selected AP stalls too long.
module opendap_ap_mux
    import opendap_ap_pkg::*;
#(
    parameter int N_AP           = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      swclk,
    input  logic                      rst_por,
    input  logic [AP_SEL_W-1:0]       ap_sel,
    input  logic [AP_ADDR_W-1:0]      ap_addr,
    input  logic [AP_DATA_W-1:0]      ap_wdata,
    input  logic                      ap_wen,
    input  logic                      ap_ren,
    input  logic                      ap_abort,
    output logic [AP_DATA_W-1:0]      ap_rdata,
    output logic                      ap_rdy,
    output logic                      ap_err,
    output logic [AP_ADDR_W-1:0]      apx_addr,
    output logic [AP_DATA_W-1:0]      apx_wdata,
    output logic [N_AP-1:0]           apx_wen,
    output logic [N_AP-1:0]           apx_ren,
    output logic [N_AP-1:0]           apx_abort,
    input  logic [AP_DATA_W*N_AP-1:0] apx_rdata,
    input  logic [N_AP-1:0]           apx_rdy,
    input  logic [N_AP-1:0]           apx_err,
    output logic                      timeout_evt
);

    localparam logic [AP_SEL_W-1:0] N_AP_SEL = AP_SEL_W'(N_AP);

    ap_state_e           state_q, state_d;
    logic [AP_SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic                to_err_q, to_err_d;

    logic                 rdy_sel;
    logic                 err_sel;
    logic [AP_DATA_W-1:0] rdata_sel;
    logic                 accept;
    logic                 cnt_clear;
    logic                 cnt_tc;
    logic                 to_fire;

    assign apx_addr  = ap_addr;
    assign apx_wdata = ap_wdata;

    // Unmapped selections fall through to the defaults: ready, zero data, no error.
    always_comb begin
        rdy_sel   = 1'b1;
        err_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < N_AP; i++) begin
            if (cur_sel_q == AP_SEL_W'(i)) begin
                rdy_sel   = apx_rdy[i];
                err_sel   = apx_err[i];
                rdata_sel = apx_rdata[i*AP_DATA_W +: AP_DATA_W];
            end
        end
    end

    assign ap_rdata = rdata_sel;
    assign ap_err   = to_err_q | err_sel;

    always_comb begin
        state_d     = state_q;
        cur_sel_d   = cur_sel_q;
        to_err_d    = to_err_q;
        cnt_clear   = 1'b0;
        to_fire     = 1'b0;
        accept      = 1'b0;
        apx_wen     = '0;
        apx_ren     = '0;
        apx_abort   = '0;
        ap_rdy      = (state_q == ST_IDLE) ? rdy_sel : 1'b0;

        // Reset silences every downstream strobe, including a pending abort.
        if (rst_por) begin
            ap_rdy = apx_rdy[0];
        end else begin
            accept = (ap_wen | ap_ren) & ap_rdy & ~ap_abort;
            if (ap_abort) begin
                apx_abort = '1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cur_sel_d = ap_sel;
                        to_err_d  = 1'b0;
                        for (int i = 0; i < N_AP; i++) begin
                            if (ap_sel == AP_SEL_W'(i)) begin
                                apx_wen[i] = ap_wen;
                                apx_ren[i] = ap_ren;
                            end
                        end
                        if (ap_sel < N_AP_SEL) begin
                            state_d   = ST_BUSY;
                            cnt_clear = 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    // Completion beats a same-cycle terminal count.
                    if (ap_abort) begin
                        state_d   = ST_IDLE;
                        cnt_clear = 1'b1;
                    end else if (rdy_sel) begin
                        state_d = ST_IDLE;
                    end else if (cnt_tc) begin
                        to_fire  = 1'b1;
                        state_d  = ST_IDLE;
                        to_err_d = 1'b1;
                        for (int i = 0; i < N_AP; i++) begin
                            if (cur_sel_q == AP_SEL_W'(i)) begin
                                apx_abort[i] = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign timeout_evt = to_fire;

    always_ff @(posedge swclk) begin
        if (rst_por) begin
            state_q   <= ST_IDLE;
            cur_sel_q <= '0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            to_err_q  <= to_err_d;
        end
    end

    opendap_ap_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .swclk  (swclk),
        .rst_por(rst_por),
        .clear  (cnt_clear),
        .enable (state_q == ST_BUSY),
        .tc     (cnt_tc)
    );

endmodule

// File: doc/opendap_ap_mux.md
OPENDAP_AP_MUX -- requirements
Module: opendap_ap_mux

Interface
REQ-001 SHALL have parameter N_AP, default 4, number of downstream APs (legal 1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, BUSY cycles before forced abort (0 = timeout disabled).
REQ-003 SHALL have port swclk  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_por  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports ap_sel/ap_addr/ap_wdata  in  8/6/32  upstream AP select, register address, write data.
REQ-006 SHALL have ports ap_wen/ap_ren/ap_abort  in  1 each  upstream write/read strobes and abort, single-cycle pulses.
REQ-007 SHALL have ports ap_rdata/ap_rdy/ap_err  out  32/1/1  upstream read data, ready, error.
REQ-008 SHALL have ports apx_addr/apx_wdata  out  6/32  ap_addr/ap_wdata broadcast unregistered to every AP.
REQ-009 SHALL have ports apx_wen/apx_ren/apx_abort  out  N_AP each  per-AP strobes.
REQ-010 SHALL have ports apx_rdata/apx_rdy/apx_err  in  32*N_AP/N_AP/N_AP  per-AP read data (AP i at bits 32i+31:32i), ready, error.
REQ-011 SHALL have port timeout_evt  out  1  one-cycle pulse when a timeout abort fires.

Function
REQ-012 SHALL track registered cur_sel (8 bits) = ap_sel of last accepted access; mapped iff cur_sel < N_AP.
REQ-013 SHALL implement FSM states IDLE and BUSY.
REQ-014 IDLE: ap_rdy SHALL equal apx_rdy[cur_sel] if mapped, else 1.
REQ-015 Accept = (ap_wen|ap_ren) & ap_rdy & !ap_abort; on accept, SHALL drive apx_wen/apx_ren[ap_sel] combinationally in the same cycle and load cur_sel <= ap_sel.
REQ-016 Accept to a mapped AP SHALL move to BUSY; accept to an unmapped AP SHALL stay IDLE, completing with ap_rdata = 0 and ap_err = 0.
REQ-017 BUSY: ap_rdy SHALL be 0, including the cycle after accept regardless of apx_rdy; BUSY -> IDLE on the first BUSY cycle with apx_rdy[cur_sel] = 1.
REQ-018 Strobes arriving with ap_rdy = 0 SHALL be ignored; no apx strobe, no state change.
REQ-019 ap_rdata SHALL equal apx_rdata[cur_sel] when mapped, else 0 (combinational mux on registered cur_sel).
REQ-020 ap_err SHALL equal to_err | (mapped & apx_err[cur_sel]).
REQ-021 to_err SHALL be a sticky register, cleared on the next accept.
REQ-022 A 16-bit BUSY counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-023 With TIMEOUT_CYCLES != 0, count = TIMEOUT_CYCLES-1 in BUSY SHALL pulse apx_abort[cur_sel] and timeout_evt, set to_err, and go to IDLE next cycle.
REQ-024 ap_abort SHALL be broadcast to all apx_abort bits the same cycle; in BUSY it SHALL force IDLE next cycle, clear the counter and leave to_err unchanged.
REQ-025 ap_abort coincident with a strobe: abort wins; the strobe SHALL NOT be forwarded.
REQ-026 apx_rdy[cur_sel] = 1 in the same BUSY cycle as the timeout terminal count: completion wins; no abort, no to_err.

Reset
REQ-027 While rst_por = 1 at a clock edge: state SHALL be IDLE, cur_sel = 0, counter = 0, to_err = 0.
REQ-028 During and after reset, all apx strobes and timeout_evt SHALL be 0, and ap_rdy SHALL follow apx_rdy[0].
REQ-029 Reset mid-BUSY SHALL drop the access without issuing any abort.

Structure
REQ-030 Shared package opendap_ap_pkg SHALL hold the FSM state encoding, AP_SEL_W = 8, AP_ADDR_W = 6, AP_DATA_W = 32 and the N_AP_MAX = 8 constant.
REQ-031 The timeout counter SHALL be one sub-module, opendap_ap_timeout: inputs clear/enable, output terminal-count pulse; all else stays flat.

Verification
REQ-032 Read ap_sel = 1, AP1 drops apx_rdy for 3 cycles, apx_rdata[1] = 0x12345678 -> one apx_ren[1] pulse; ap_rdy low 4 cycles; ap_rdata = 0x12345678, ap_err = 0.
REQ-033 Write ap_sel = 0x20 with N_AP = 4 -> no apx strobe; ap_rdy stays 1; subsequent ap_rdata = 0, ap_err = 0.
REQ-034 TIMEOUT_CYCLES = 8, AP2 never readies after a read -> apx_abort[2] and timeout_evt pulse on BUSY cycle 8; IDLE next cycle; ap_err = 1 until the next accept.
REQ-035 ap_abort and ap_wen in the same cycle while IDLE -> all apx_abort = 1 for that cycle; no apx_wen; state stays IDLE.
REQ-036 rst_por asserted 2 cycles into BUSY on AP3 -> IDLE with cur_sel = 0 and no apx_abort pulse.
REQ-037 Strobe issued while BUSY on AP0 -> ignored; exactly one apx_ren[0] pulse observed overall.
